// File: rtl/cpu_pkg.sv
// Shared types and widths for the pipeline datapath.
// Holds the memory-stage FSM encoding and the MEM/WB register layout.
package cpu_pkg;

    localparam int WORD_W     = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    typedef struct packed {
        logic                  reg_write;
        logic                  mem_to_reg;
        logic [WORD_W-1:0]     rdata;
        logic [WORD_W-1:0]     alu_out;
        logic [REG_ADDR_W-1:0] wn;
    } memwb_t;

endpackage

// File: rtl/dmem_req_fsm.sv
// Data-memory request sequencer: issues one word load/store, waits for ack
// with a bounded counter, and buffers the read data for the MEM/WB load.
module dmem_req_fsm
    import cpu_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [WORD_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [WORD_W-1:0] rdata,
    input  logic              ack,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [WORD_W-1:0] dmem_addr,
    output logic [WORD_W-1:0] dmem_wdata,
    output logic              stall,
    output logic              done,
    output logic              faulted,
    output logic              misaligned,
    output logic              timeout,
    output logic [WORD_W-1:0] rbuf
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    mem_state_t    state, state_n;
    logic [CW-1:0] cnt;
    logic          mem_op, aligned, stall_c, issue;

    assign mem_op  = mem_read | mem_write;
    assign aligned = (addr[1:0] == 2'b00);
    assign issue   = (state == IDLE) & mem_op & aligned;

    always_comb begin
        state_n    = state;
        stall_c    = 1'b0;
        timeout    = 1'b0;
        misaligned = 1'b0;
        case (state)
            IDLE: begin
                if (mem_op && aligned) begin
                    state_n = REQ;
                    stall_c = 1'b1;
                end else if (mem_op) begin
                    misaligned = 1'b1;
                end
            end
            REQ: begin
                stall_c = 1'b1;
                if (ack) begin
                    state_n = DONE;
                end else if (cnt == CNT_LAST) begin
                    timeout = 1'b1;
                    state_n = DONE;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Reset must drop stall immediately even while the held inputs still
    // describe an aligned memory op.
    assign stall = stall_c & ~rst;
    assign done  = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            faulted    <= 1'b0;
            rbuf       <= '0;
        end else begin
            state    <= state_n;
            dmem_req <= (state_n == REQ);
            if (state == IDLE) begin
                cnt <= '0;
            end else if (state == REQ && cnt != CNT_LAST) begin
                cnt <= cnt + 1'b1;
            end
            if (issue) begin
                dmem_we    <= ~mem_read;
                dmem_addr  <= addr;
                dmem_wdata <= wdata;
                faulted    <= 1'b0;
            end
            if (state == REQ && ack) begin
                rbuf <= rdata;
            end
            if (timeout) begin
                faulted <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: drives the data-memory port through dmem_req_fsm, resolves beq,
// and owns the MEM/WB register and the sticky fault flag.
module mem_stage
    import cpu_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RegWrite,
    input  logic                  MemtoReg,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic                  Branch,
    input  logic [WORD_W-1:0]     ALUout,
    input  logic [WORD_W-1:0]     wd,
    input  logic [WORD_W-1:0]     PC_in,
    input  logic [REG_ADDR_W-1:0] RegisterFile_wn,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [WORD_W-1:0]     dmem_addr,
    output logic [WORD_W-1:0]     dmem_wdata,
    input  logic [WORD_W-1:0]     dmem_rdata,
    input  logic                  dmem_ack,
    output logic                  stall,
    output logic                  pc_src,
    output logic [WORD_W-1:0]     pc_branch,
    output logic                  wb_RegWrite,
    output logic                  wb_MemtoReg,
    output logic [WORD_W-1:0]     wb_rdata,
    output logic [WORD_W-1:0]     wb_ALUout,
    output logic [REG_ADDR_W-1:0] wb_wn,
    output logic                  mem_fault
);

    memwb_t            memwb;
    logic              done, faulted, misaligned, timeout;
    logic [WORD_W-1:0] rbuf;

    dmem_req_fsm #(.TIMEOUT(TIMEOUT)) u_fsm (
        .clk        (clk),
        .rst        (rst),
        .mem_read   (MemRead),
        .mem_write  (MemWrite),
        .addr       (ALUout),
        .wdata      (wd),
        .rdata      (dmem_rdata),
        .ack        (dmem_ack),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .stall      (stall),
        .done       (done),
        .faulted    (faulted),
        .misaligned (misaligned),
        .timeout    (timeout),
        .rbuf       (rbuf)
    );

    assign pc_src    = Branch & (ALUout == '0);
    assign pc_branch = PC_in;

    // Stall cycles and misaligned ops become bubbles: control cleared,
    // data fields left as they were so nothing downstream sees a glitch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            memwb     <= '0;
            mem_fault <= 1'b0;
        end else begin
            if (misaligned || timeout) begin
                mem_fault <= 1'b1;
            end
            if (stall || misaligned) begin
                memwb.reg_write  <= 1'b0;
                memwb.mem_to_reg <= 1'b0;
            end else if (done) begin
                memwb.reg_write  <= RegWrite & ~faulted;
                memwb.mem_to_reg <= MemtoReg;
                memwb.rdata      <= rbuf;
                memwb.alu_out    <= ALUout;
                memwb.wn         <= RegisterFile_wn;
            end else begin
                memwb.reg_write  <= RegWrite;
                memwb.mem_to_reg <= MemtoReg;
                memwb.alu_out    <= ALUout;
                memwb.wn         <= RegisterFile_wn;
            end
        end
    end

    assign wb_RegWrite = memwb.reg_write;
    assign wb_MemtoReg = memwb.mem_to_reg;
    assign wb_rdata    = memwb.rdata;
    assign wb_ALUout   = memwb.alu_out;
    assign wb_wn       = memwb.wn;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: table of single-cycle ops plus hand-written
// load/store/timeout/misalign/reset sequences.
module tb_mem_stage;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWrite, MemtoReg, MemRead, MemWrite, Branch;
    logic [31:0] ALUout, wd, PC_in;
    logic [4:0]  RegisterFile_wn;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        dmem_ack;
    logic        stall, pc_src;
    logic [31:0] pc_branch;
    logic        wb_RegWrite, wb_MemtoReg;
    logic [31:0] wb_rdata, wb_ALUout;
    logic [4:0]  wb_wn;
    logic        mem_fault;

    int checks = 0;
    int errors = 0;

    mem_stage #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .RegWrite(RegWrite), .MemtoReg(MemtoReg), .MemRead(MemRead),
        .MemWrite(MemWrite), .Branch(Branch),
        .ALUout(ALUout), .wd(wd), .PC_in(PC_in), .RegisterFile_wn(RegisterFile_wn),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .stall(stall), .pc_src(pc_src), .pc_branch(pc_branch),
        .wb_RegWrite(wb_RegWrite), .wb_MemtoReg(wb_MemtoReg),
        .wb_rdata(wb_rdata), .wb_ALUout(wb_ALUout), .wb_wn(wb_wn),
        .mem_fault(mem_fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rw, input logic m2r, input logic mr, input logic mw,
                         input logic br, input logic [31:0] alu, input logic [31:0] d,
                         input logic [31:0] pc, input logic [4:0] wn);
        RegWrite = rw; MemtoReg = m2r; MemRead = mr; MemWrite = mw; Branch = br;
        ALUout = alu; wd = d; PC_in = pc; RegisterFile_wn = wn;
    endtask

    // Walk a memory op from IDLE to DONE, acking after ack_delay REQ cycles.
    // Returns stall cycles seen and whether the request fields stayed put.
    task automatic run_mem(input int ack_delay, input logic exp_we, input logic [31:0] exp_addr,
                           input logic [31:0] exp_wdata, output int stalls, output bit stable,
                           output bit bubble_ok);
        int wait_cyc;
        wait_cyc  = 0;
        stalls    = 0;
        stable    = 1'b1;
        bubble_ok = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (!stall) break;
            if (stalls > 0 && wb_RegWrite !== 1'b0) bubble_ok = 1'b0;
            stalls++;
            if (dmem_req) begin
                if (dmem_we !== exp_we || dmem_addr !== exp_addr || dmem_wdata !== exp_wdata)
                    stable = 1'b0;
                dmem_ack = (wait_cyc == ack_delay);
                wait_cyc++;
            end else begin
                dmem_ack = 1'b0;
            end
            @(negedge clk);
            #1;
        end
        dmem_ack = 1'b0;
    endtask

    typedef struct {
        logic        rw, m2r, br;
        logic [31:0] alu, pc;
        logic [4:0]  wn;
        logic        e_pc_src;
        logic        e_rw, e_m2r;
    } vec_t;

    vec_t vecs[5];
    int   stalls;
    bit   stable, bubble_ok;

    initial begin
        vecs[0] = '{rw:1, m2r:0, br:0, alu:32'h55,       pc:32'h0,  wn:5'd3,  e_pc_src:0, e_rw:1, e_m2r:0};
        vecs[1] = '{rw:0, m2r:0, br:1, alu:32'h0,        pc:32'h40, wn:5'd0,  e_pc_src:1, e_rw:0, e_m2r:0};
        vecs[2] = '{rw:0, m2r:0, br:1, alu:32'h5,        pc:32'h80, wn:5'd0,  e_pc_src:0, e_rw:0, e_m2r:0};
        vecs[3] = '{rw:1, m2r:0, br:0, alu:32'h0,        pc:32'h44, wn:5'd31, e_pc_src:0, e_rw:1, e_m2r:0};
        vecs[4] = '{rw:1, m2r:1, br:0, alu:32'hFFFFFFFF, pc:32'h10, wn:5'd17, e_pc_src:0, e_rw:1, e_m2r:1};

        rst = 1'b1;
        dmem_ack = 1'b0;
        dmem_rdata = 32'h0;
        drive(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0);
        #12;
        chk("reset stall", 32'(stall), 32'h0);
        chk("reset dmem_req", 32'(dmem_req), 32'h0);
        chk("reset mem_fault", 32'(mem_fault), 32'h0);
        chk("reset wb_RegWrite", 32'(wb_RegWrite), 32'h0);
        chk("reset wb_wn", 32'(wb_wn), 32'h0);
        chk("reset wb_ALUout", wb_ALUout, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Single-cycle ops: branch resolved combinationally, MEM/WB at next edge
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive(vecs[i].rw, vecs[i].m2r, 0, 0, vecs[i].br, vecs[i].alu, 32'h0, vecs[i].pc, vecs[i].wn);
            #1;
            chk($sformatf("v%0d pc_src", i), 32'(pc_src), 32'(vecs[i].e_pc_src));
            chk($sformatf("v%0d pc_branch", i), pc_branch, vecs[i].pc);
            chk($sformatf("v%0d stall", i), 32'(stall), 32'h0);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d wb_ALUout", i), wb_ALUout, vecs[i].alu);
            chk($sformatf("v%0d wb_wn", i), 32'(wb_wn), 32'(vecs[i].wn));
            chk($sformatf("v%0d wb_RegWrite", i), 32'(wb_RegWrite), 32'(vecs[i].e_rw));
            chk($sformatf("v%0d wb_MemtoReg", i), 32'(wb_MemtoReg), 32'(vecs[i].e_m2r));
        end

        // ack outside REQ must not matter
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 32'h77, 32'h0, 32'h0, 5'd4);
        dmem_ack = 1'b1;
        #1;
        chk("stray ack stall", 32'(stall), 32'h0);
        @(posedge clk);
        #1;
        chk("stray ack dmem_req", 32'(dmem_req), 32'h0);
        chk("stray ack wb_ALUout", wb_ALUout, 32'h77);
        dmem_ack = 1'b0;

        // Load, ack in first REQ cycle
        @(negedge clk);
        drive(1, 1, 1, 0, 0, 32'h100, 32'h0, 32'h0, 5'd5);
        dmem_rdata = 32'hDEADBEEF;
        #1;
        run_mem(0, 1'b0, 32'h100, 32'h0, stalls, stable, bubble_ok);
        chk("load stall cycles", 32'(stalls), 32'd2);
        chk("load req fields", 32'(stable), 32'h1);
        chk("load bubble", 32'(bubble_ok), 32'h1);
        chk("load req drop", 32'(dmem_req), 32'h0);
        dmem_rdata = 32'h0;
        @(posedge clk);
        #1;
        chk("load wb_rdata", wb_rdata, 32'hDEADBEEF);
        chk("load wb_MemtoReg", 32'(wb_MemtoReg), 32'h1);
        chk("load wb_RegWrite", 32'(wb_RegWrite), 32'h1);
        chk("load wb_wn", 32'(wb_wn), 32'd5);
        chk("load wb_ALUout", wb_ALUout, 32'h100);

        // Store, ack after 3 wait cycles
        @(negedge clk);
        drive(0, 0, 0, 1, 0, 32'h200, 32'h1234, 32'h0, 5'd0);
        #1;
        run_mem(3, 1'b1, 32'h200, 32'h1234, stalls, stable, bubble_ok);
        chk("store stall cycles", 32'(stalls), 32'd5);
        chk("store req fields", 32'(stable), 32'h1);
        @(posedge clk);
        #1;
        chk("store wb_RegWrite", 32'(wb_RegWrite), 32'h0);
        chk("store wb_ALUout", wb_ALUout, 32'h200);
        chk("store mem_fault", 32'(mem_fault), 32'h0);

        // Misaligned load: no request, no stall, bubble, fault
        @(negedge clk);
        drive(1, 1, 1, 0, 0, 32'h102, 32'h0, 32'h0, 5'd6);
        #1;
        chk("misalign stall", 32'(stall), 32'h0);
        @(posedge clk);
        #1;
        chk("misalign dmem_req", 32'(dmem_req), 32'h0);
        chk("misalign mem_fault", 32'(mem_fault), 32'h1);
        chk("misalign wb_RegWrite", 32'(wb_RegWrite), 32'h0);
        chk("misalign wb_ALUout kept", wb_ALUout, 32'h200);

        // Reset in the middle of REQ
        @(negedge clk);
        drive(1, 1, 1, 0, 0, 32'h300, 32'h0, 32'h0, 5'd7);
        @(posedge clk);
        #1;
        chk("midreq dmem_req", 32'(dmem_req), 32'h1);
        rst = 1'b1;
        #1;
        chk("midreq rst dmem_req", 32'(dmem_req), 32'h0);
        chk("midreq rst stall", 32'(stall), 32'h0);
        chk("midreq rst mem_fault", 32'(mem_fault), 32'h0);
        chk("midreq rst wb_ALUout", wb_ALUout, 32'h0);
        chk("midreq rst wb_wn", 32'(wb_wn), 32'h0);
        chk("midreq rst wb_rdata", wb_rdata, 32'h0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0);
        @(negedge clk);
        rst = 1'b0;

        // Timeout: no ack at all
        @(negedge clk);
        drive(1, 1, 1, 0, 0, 32'h400, 32'h0, 32'h0, 5'd9);
        #1;
        run_mem(1000, 1'b0, 32'h400, 32'h0, stalls, stable, bubble_ok);
        chk("timeout stall cycles", 32'(stalls), 32'(TO + 1));
        chk("timeout mem_fault", 32'(mem_fault), 32'h1);
        @(posedge clk);
        #1;
        chk("timeout wb_RegWrite", 32'(wb_RegWrite), 32'h0);
        chk("timeout wb_ALUout", wb_ALUout, 32'h400);
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 32'h99, 32'h0, 32'h0, 5'd2);
        #1;
        chk("resume stall", 32'(stall), 32'h0);
        @(posedge clk);
        #1;
        chk("resume wb_RegWrite", 32'(wb_RegWrite), 32'h1);
        chk("resume wb_ALUout", wb_ALUout, 32'h99);
        chk("fault sticky", 32'(mem_fault), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
